fp_addsub_sequencer: RTL and testbench
======================================

# fp_addsub_sequencer

Initiator-side front end for the single-precision add/sub core. Accepts operand pairs over a valid/ready handshake and drives the core's `a`/`b`/`operation_select` inputs from registers. It tracks operations in flight through the core's fixed latency and captures each result into a small FIFO, presented on a valid/ready output. Credit-based admission guarantees a captured result always has a FIFO slot, so the core never needs to stall.

## Interface
- `WIDTH`, 32: operand/result width (IEEE-754 single).
- `CORE_LATENCY`, 2: clock edges from core operand update to core result valid; legal range 1..8.
- `FIFO_DEPTH`, 4: result buffer entries; must be a power of two, 2..16.
- `TAG_BITS`, 4: user tag carried alongside each operation.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: operand pair present.
- `in_ready` out 1: sequencer can accept.
- `in_a`, `in_b` in WIDTH: operands.
- `in_op` in 1: 0 = add, 1 = subtract (a − b).
- `in_tag` in TAG_BITS: user tag.
- `core_a`, `core_b` out WIDTH: registered operands to the core.
- `core_op` out 1: registered `operation_select` to the core.
- `core_result` in WIDTH: core output.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts.
- `out_result` out WIDTH: head-of-FIFO result.
- `out_tag` out TAG_BITS: tag of the head entry.
- `out_op` out 1: op of the head entry.
- `occupancy` out clog2(FIFO_DEPTH+1): in-flight count plus FIFO count.

## Operation
- Accept occurs when `in_valid && in_ready` is true at a rising edge. At that edge, `core_a`, `core_b` and `core_op` load `in_a`, `in_b` and `in_op`. With no accept, they hold their values.
- In-flight tracking uses a CORE_LATENCY-stage shift register of {valid, tag, op}. Stage 0 loads on every edge, with valid = accept. The final stage's valid marks the edge at which `core_result` is captured.
- Capture writes {core_result, tag, op} into the FIFO at the edge where the final stage is valid.
- FIFO: circular buffer with write/read pointers of clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH, plus a count. Output is show-ahead: `out_*` reflect the head entry combinationally. `out_valid` = (count ≠ 0).
- Pop occurs when `out_valid && out_ready` at a rising edge. Push and pop in the same edge leave the count unchanged, and both pointers advance.
- Credit rule: `occupancy` = in-flight valid stages + FIFO count. `in_ready` = (occupancy < FIFO_DEPTH) and not reset. `in_ready` does not depend on `out_ready`, so a same-cycle pop frees a credit only from the next cycle.
- Overflow and underflow are impossible by construction. Results leave strictly in acceptance order.
- No arithmetic is done in this block. Values pass through bit-exact.

## Timing
- Reset (asserted): all registers clear immediately, without waiting for a clock edge. Resulting values:
  - `core_a`, `core_b`, `core_op`, `out_result`, `out_tag`, `out_op` are 0.
  - `out_valid` is 0, `occupancy` is 0, `in_ready` is 0.
- Reset release: `in_ready` goes to 1 combinationally after release. The first accept is possible at the first rising edge following release.
- Latency: accept at edge k → capture at edge k+CORE_LATENCY → `out_valid` high after that edge. With `out_ready`=1, the pop occurs at edge k+CORE_LATENCY+1.
- Throughput: one accept per cycle sustained while `out_ready`=1 and occupancy stays below FIFO_DEPTH.
- Reset mid-operation: in-flight operations and FIFO contents are discarded. No result is emitted for them.
- Back-to-back accepts: core operands change every cycle, and each capture pairs with the correct tag.

## Test plan
Bench uses a behavioural core with CORE_LATENCY=2 and FIFO_DEPTH=4.

- **Single add.** Reset, then accept a=40400000, b=40800000, op=0, tag=1. Required: `out_valid` rises after edge k+2, with `out_result`=40E00000, `out_tag`=1, `out_op`=0.
- **Stream of four, `out_ready`=1.** Issue four back-to-back ops:
  - 40A00000−40000000
  - C0800000+40800000
  - C0A00000−C0000000
  - 00000000+00000000

  Required results in order: 40400000, 00000000, C0400000, 00000000. Tags are preserved.
- **Backpressure.** Hold `out_ready`=0 and `in_valid`=1. Required:
  - Four accepts occur, then `in_ready`=0 and `occupancy`=4.
  - A fifth op is held until `out_ready`=1 pops an entry. It is accepted one cycle later.
  - Output order is intact.
- **Simultaneous push/pop with full wrap.** Run 10 continuous ops with `out_ready` toggling every cycle. Required: pointers wrap with no loss or duplication, and `occupancy` never exceeds 4.
- **Reset mid-flight.** Assert reset one cycle after an accept. Required:
  - All outputs go to 0 immediately.
  - No result appears after release.
  - `in_ready` is 1 after release.
- **Idle hold.** With no accepts, `core_a`, `core_b` and `core_op` keep their last values, and `out_valid` stays 0.

Source files
------------

// File: rtl/fp_addsub_sequencer.sv
// ---------------------------------------------------------------------------
// fp_addsub_sequencer
//
// Initiator-side front end for the single-precision add/sub core. Operand
// pairs arrive on a valid/ready handshake and are registered onto the core
// inputs. A shift register follows each operation through the core's fixed
// latency. When an operation leaves the final stage, the core result is
// written into a small show-ahead FIFO together with the operation's tag and
// op bit. Admission is credit based: an operation is only accepted when it
// is guaranteed a FIFO slot. This means the core never has to stall and the
// FIFO can never overflow. No arithmetic is done here; all values pass
// through bit-exact.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : asynchronous, active-high; clears every register
//   in_valid     : operand pair present
//   in_ready     : sequencer can accept (credit available, not in reset)
//   in_a, in_b   : operands
//   in_op        : 0 = add, 1 = subtract (a - b)
//   in_tag       : user tag carried with the operation
//   core_a/b     : registered operands to the core
//   core_op      : registered operation_select to the core
//   core_result  : core output, sampled CORE_LATENCY edges after operand load
//   out_valid    : head-of-FIFO entry present
//   out_ready    : consumer accepts the head entry
//   out_result   : head-of-FIFO result
//   out_tag      : head-of-FIFO tag
//   out_op       : head-of-FIFO op
//   occupancy    : operations in flight plus entries in the FIFO
// ---------------------------------------------------------------------------
module fp_addsub_sequencer #(
    parameter int WIDTH        = 32,
    parameter int CORE_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int TAG_BITS     = 4,
    localparam int OCC_W       = $clog2(FIFO_DEPTH + 1),
    localparam int PTR_W       = $clog2(FIFO_DEPTH)
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic                in_op,
    input  logic [TAG_BITS-1:0] in_tag,

    output logic [WIDTH-1:0]    core_a,
    output logic [WIDTH-1:0]    core_b,
    output logic                core_op,
    input  logic [WIDTH-1:0]    core_result,

    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_result,
    output logic [TAG_BITS-1:0] out_tag,
    output logic                out_op,

    output logic [OCC_W-1:0]    occupancy
);

    // The sum is kept wide enough to hold every pipeline stage plus a full
    // FIFO. The credit rule keeps the real value at or below FIFO_DEPTH.
    localparam int SUM_W = $clog2(CORE_LATENCY + FIFO_DEPTH + 1);

    logic                    accept;
    logic                    pop;
    logic                    capture;

    logic [CORE_LATENCY-1:0] pipe_valid;
    logic [TAG_BITS-1:0]     pipe_tag [CORE_LATENCY];
    logic [CORE_LATENCY-1:0] pipe_op;

    logic [WIDTH-1:0]        mem_result [FIFO_DEPTH];
    logic [TAG_BITS-1:0]     mem_tag    [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   mem_op;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [OCC_W-1:0]        count;

    logic [SUM_W-1:0]        inflight;
    logic [SUM_W-1:0]        occ_sum;

    // ------------------------------------------------------------------
    // Credit accounting and handshakes
    // ------------------------------------------------------------------
    always_comb begin
        inflight = '0;
        for (int i = 0; i < CORE_LATENCY; i++) begin
            inflight = inflight + SUM_W'(pipe_valid[i]);
        end
    end

    assign occ_sum   = SUM_W'(count) + inflight;
    assign occupancy = occ_sum[OCC_W-1:0];

    // in_ready does not look at out_ready. A pop in this cycle therefore
    // returns its credit only on the following cycle. This keeps the
    // input and output handshakes free of a combinational path between them.
    assign in_ready  = !reset && (occ_sum < SUM_W'(FIFO_DEPTH));
    assign accept    = in_valid && in_ready;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    assign capture   = pipe_valid[CORE_LATENCY-1];

    // ------------------------------------------------------------------
    // Operand registers driving the core
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_a  <= '0;
            core_b  <= '0;
            core_op <= 1'b0;
        end else if (accept) begin
            core_a  <= in_a;
            core_b  <= in_b;
            core_op <= in_op;
        end
    end

    // ------------------------------------------------------------------
    // In-flight tracker: stage 0 loads on every edge. The stage's valid bit
    // follows accept, so a bubble is recorded when nothing is accepted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid <= '0;
            pipe_op    <= '0;
            for (int i = 0; i < CORE_LATENCY; i++) begin
                pipe_tag[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_op[0]    <= in_op;
            pipe_tag[0]   <= in_tag;
            for (int i = 1; i < CORE_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_op[i]    <= pipe_op[i-1];
                pipe_tag[i]   <= pipe_tag[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO storage. The FIFO is cleared on reset, so the show-ahead
    // outputs read zero while the FIFO is empty after reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_op <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_result[i] <= '0;
                mem_tag[i]    <= '0;
            end
        end else if (capture) begin
            mem_result[wr_ptr] <= core_result;
            mem_tag[wr_ptr]    <= pipe_tag[CORE_LATENCY-1];
            mem_op[wr_ptr]     <= pipe_op[CORE_LATENCY-1];
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({capture, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_result = mem_result[rd_ptr];
    assign out_tag    = mem_tag[rd_ptr];
    assign out_op     = mem_op[rd_ptr];

endmodule

// File: tb/tb_fp_addsub_sequencer.sv
module tb_fp_addsub_sequencer;

    localparam int W  = 32;
    localparam int L  = 2;
    localparam int D  = 4;
    localparam int TB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_op;
    logic [TB-1:0] in_tag;
    logic [W-1:0]  core_a;
    logic [W-1:0]  core_b;
    logic          core_op;
    logic [W-1:0]  core_result;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [TB-1:0] out_tag;
    logic          out_op;
    logic [2:0]    occupancy;

    always #5 clk = ~clk;

    fp_addsub_sequencer #(
        .WIDTH(W), .CORE_LATENCY(L), .FIFO_DEPTH(D), .TAG_BITS(TB)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .core_a(core_a), .core_b(core_b), .core_op(core_op),
        .core_result(core_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_op(out_op),
        .occupancy(occupancy)
    );

    // ---------------- floating-point helpers (normal numbers and zero) -----
    function automatic real to_real(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'({3'b000, f[30:23]} + 11'd896), f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] from_real(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52];
        if (e == 11'd0) return {d[63], 31'b0};
        return {d[63], 8'(e - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic op);
        return from_real(op ? (to_real(a) - to_real(b)) : (to_real(a) + to_real(b)));
    endfunction

    function automatic logic [31:0] int_to_fp(input int v);
        return from_real(real'(v));
    endfunction

    // Behavioural core: one register stage after the sequencer's operand
    // registers gives a result that is valid CORE_LATENCY edges after load.
    logic [W-1:0] core_stage = '0;
    always @(posedge clk) core_stage <= fp_ref(core_a, core_b, core_op);
    assign core_result = core_stage;

    // ---------------- reference model ----------------
    logic [W-1:0]  q_res   [$];
    logic [TB-1:0] q_tag   [$];
    logic          q_op    [$];
    int            q_avail [$];
    int            edge_cnt = 0;
    logic [W-1:0]  last_a  = '0;
    logic [W-1:0]  last_b  = '0;
    logic          last_op = 1'b0;
    logic          rst_m   = 1'b1;
    int            rdy_mode = 1;
    logic          ordy_t  = 1'b0;
    int            tests_run = 0;
    int            tests_failed = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        q_res.delete(); q_tag.delete(); q_op.delete(); q_avail.delete();
        last_a = '0; last_b = '0; last_op = 1'b0;
    endtask

    // One clock cycle: drive, check outputs, advance the model across the edge.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [3:0] tag, input logic [31:0] exp_r,
                        output logic acc);
        logic ordy, ovm, irm, pp;
        case (rdy_mode)
            0: ordy = 1'b0;
            1: ordy = 1'b1;
            2: begin ordy_t = ~ordy_t; ordy = ordy_t; end
            default: ordy = 1'($urandom_range(0, 1));
        endcase
        in_valid = v; in_a = a; in_b = b; in_op = op; in_tag = tag; out_ready = ordy;
        #1;
        irm = !rst_m && (q_res.size() < D);
        ovm = (q_res.size() != 0) && (q_avail[0] <= edge_cnt);
        check("in_ready", 32'(in_ready), 32'(irm));
        check("out_valid", 32'(out_valid), 32'(ovm));
        check("occupancy", 32'(occupancy), 32'(q_res.size()));
        check("occ_bound", 32'(occupancy <= 3'(D)), 32'd1);
        check("core_a_hold", core_a, last_a);
        check("core_b_hold", core_b, last_b);
        check("core_op_hold", 32'(core_op), 32'(last_op));
        if (ovm) begin
            check("out_result", out_result, q_res[0]);
            check("out_tag", 32'(out_tag), 32'(q_tag[0]));
            check("out_op", 32'(out_op), 32'(q_op[0]));
        end
        acc = v && irm;
        pp  = ovm && ordy;
        @(posedge clk);
        edge_cnt++;
        if (pp) begin
            void'(q_res.pop_front()); void'(q_tag.pop_front());
            void'(q_op.pop_front());  void'(q_avail.pop_front());
        end
        if (acc) begin
            q_res.push_back(exp_r); q_tag.push_back(tag);
            q_op.push_back(op);     q_avail.push_back(edge_cnt + L);
            last_a = a; last_b = b; last_op = op;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 4'd0, '0, acc);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op,
                        input logic [3:0] tag, input logic [31:0] exp_r);
        logic acc;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, a, b, op, tag, exp_r, acc);
            if (acc) return;
        end
        check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_rand(input logic [3:0] tag);
        logic [31:0] a, b;
        logic op;
        a  = int_to_fp(int'($urandom_range(0, 200)) - 100);
        b  = int_to_fp(int'($urandom_range(0, 200)) - 100);
        op = 1'($urandom_range(0, 1));
        send(a, b, op, tag, fp_ref(a, b, op));
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_in_ready"},  32'(in_ready), 32'd0);
        check({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
        check({pfx, "_occupancy"}, 32'(occupancy), 32'd0);
        check({pfx, "_core_a"},    core_a, 32'd0);
        check({pfx, "_core_b"},    core_b, 32'd0);
        check({pfx, "_core_op"},   32'(core_op), 32'd0);
        check({pfx, "_out_result"}, out_result, 32'd0);
        check({pfx, "_out_tag"},   32'(out_tag), 32'd0);
        check({pfx, "_out_op"},    32'(out_op), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        logic [31:0] a, b;
        logic op;
        in_valid = 0; in_a = '0; in_b = '0; in_op = 0; in_tag = '0; out_ready = 0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        idle(2);
        reset = 1'b0; rst_m = 1'b0;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);

        // Single add: 3.0 + 4.0 = 7.0
        rdy_mode = 1;
        send(32'h40400000, 32'h40800000, 1'b0, 4'd1, 32'h40E00000);
        idle(4);

        // Stream of four back-to-back ops
        send(32'h40A00000, 32'h40000000, 1'b1, 4'd2, 32'h40400000);
        send(32'hC0800000, 32'h40800000, 1'b0, 4'd3, 32'h00000000);
        send(32'hC0A00000, 32'hC0000000, 1'b1, 4'd4, 32'hC0400000);
        send(32'h00000000, 32'h00000000, 1'b0, 4'd5, 32'h00000000);
        idle(5);

        // Backpressure: four accepts, then the fifth op is held
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) send_rand(4'(6 + i));
        a = int_to_fp(7); b = int_to_fp(-9); op = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, a, b, op, 4'd10, fp_ref(a, b, op), acc);
            check("bp_held", 32'(acc), 32'd0);
        end
        check("bp_full_occupancy", 32'(occupancy), 32'd4);
        rdy_mode = 1;
        step(1'b1, a, b, op, 4'd10, fp_ref(a, b, op), acc);
        check("bp_pop_cycle_no_accept", 32'(acc), 32'd0);
        step(1'b1, a, b, op, 4'd10, fp_ref(a, b, op), acc);
        check("bp_accept_next_cycle", 32'(acc), 32'd1);
        idle(8);

        // Continuous ops with out_ready toggling: pointers wrap several times
        rdy_mode = 2;
        for (int i = 0; i < 10; i++) send_rand(4'(i));
        idle(12);
        rdy_mode = 1;
        idle(3);

        // Randomised valid and out_ready
        rdy_mode = 3;
        for (int i = 0; i < 60; i++) begin
            a  = int_to_fp(int'($urandom_range(0, 200)) - 100);
            b  = int_to_fp(int'($urandom_range(0, 200)) - 100);
            op = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 1)), a, b, op, 4'($urandom), fp_ref(a, b, op), acc);
        end
        rdy_mode = 1;
        idle(10);

        // Idle hold: operands keep their last values, no output
        idle(5);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Reset one cycle after an accept
        send(int_to_fp(11), int_to_fp(5), 1'b0, 4'd9, int_to_fp(16));
        idle(1);
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        rst_m = 1'b1;
        model_clear();
        @(negedge clk);
        idle(2);
        reset = 1'b0; rst_m = 1'b0;
        #1;
        check("midreset_release_in_ready", 32'(in_ready), 32'd1);
        idle(6);

        // A fresh op after the mid-flight reset still completes normally
        send(32'h40400000, 32'h40800000, 1'b1, 4'd12, 32'hBF800000);
        idle(5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
